// File: rtl/cla4_seq_add32_if.sv
// Start/done handshake and operand/result bundle for the nibble-serial adder.
// The master drives the request side; the slave (the adder) drives the result side.
interface cla4_seq_add32_if #(
   parameter int unsigned WIDTH = 32
);
   logic             i_start;
   logic             i_sub;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_s;
   logic             o_co;
   logic             o_ovf;

   modport master (
      output i_start, i_sub, i_a, i_b,
      input  o_busy, o_done, o_s, o_co, o_ovf
   );

   modport slave (
      input  i_start, i_sub, i_a, i_b,
      output o_busy, o_done, o_s, o_co, o_ovf
   );
endinterface

// File: rtl/cla4_seq_add32.sv
// WIDTH-bit add/subtract built from one time-shared 4-bit carry look-ahead
// slice, one nibble per clock LSB first, with a start/busy/done handshake.
module cla4_seq_add32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   cla4_seq_add32_if.slave  bus
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = $clog2(NIB) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_carry, w_carry_nxt;
   logic [WIDTH-1:0] r_a, w_a_nxt;
   logic [WIDTH-1:0] r_b, w_b_nxt;
   logic [WIDTH-1:0] r_s, w_s_nxt;
   logic             r_co, w_co_nxt;
   logic             r_ovf, w_ovf_nxt;
   logic             r_busy;
   logic             r_done;

   logic [CW+1:0]    w_sh;
   logic [3:0]       w_na, w_nb, w_ns;
   logic [3:0]       w_g, w_p;
   logic [4:0]       w_c;

   // Current nibble of each operand register
   assign w_sh = {r_cnt, 2'b00};
   assign w_na = 4'(r_a >> w_sh);
   assign w_nb = 4'(r_b >> w_sh);

   // 4-bit carry look-ahead slice: all carries from generate/propagate in parallel
   always_comb begin
      w_g    = w_na & w_nb;
      w_p    = w_na ^ w_nb;
      w_c[0] = r_carry;
      w_c[1] = w_g[0] | (w_p[0] & r_carry);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & r_carry);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
      w_ns   = w_p ^ w_c[3:0];
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_carry_nxt = r_carry;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_s_nxt     = r_s;
      w_co_nxt    = r_co;
      w_ovf_nxt   = r_ovf;

      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.i_start) begin
               w_state_nxt = ST_BUSY;
               w_a_nxt     = bus.i_a;
               w_b_nxt     = bus.i_sub ? ~bus.i_b : bus.i_b;
               w_carry_nxt = bus.i_sub;
               w_cnt_nxt   = '0;
               w_s_nxt     = '0;
               w_co_nxt    = 1'b0;
               w_ovf_nxt   = 1'b0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            w_s_nxt     = (r_s & ~(WIDTH'(4'hF) << w_sh)) | (WIDTH'(w_ns) << w_sh);
            w_carry_nxt = w_c[4];
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == CW'(NIB - 1)) begin
               w_state_nxt = ST_DONE;
               w_co_nxt    = w_c[4];
               // Overflow: operands (b already inverted for sub) agree in sign, result does not
               w_ovf_nxt   = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_ns[3] != r_a[WIDTH-1]);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_carry <= w_carry_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_s     <= w_s_nxt;
         r_co    <= w_co_nxt;
         r_ovf   <= w_ovf_nxt;
         r_busy  <= (w_state_nxt == ST_BUSY);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   assign bus.o_busy = r_busy;
   assign bus.o_done = r_done;
   assign bus.o_s    = r_s;
   assign bus.o_co   = r_co;
   assign bus.o_ovf  = r_ovf;
endmodule

// File: tb/tb_cla4_seq_add32.sv
// Self-checking bench for cla4_seq_add32: directed vector table, multi-cycle
// corner sequences and a randomized back-to-back stream against an arithmetic model.
module tb_cla4_seq_add32;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned NIB   = WIDTH / 4;

   logic clk = 1'b0;
   logic reset_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   cla4_seq_add32_if #(.WIDTH(WIDTH)) bus ();

   cla4_seq_add32 #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] s;
      logic        co;
      logic        ovf;
   } vec_t;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Plain-arithmetic reference: returns {co, ovf, s}
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          sr;
      logic [31:0]     s;
      logic            co;
      logic            ovf;
      if (sub) begin
         s  = a - b;
         co = (ua >= ub);
         sr = sa - sb;
      end else begin
         s  = a + b;
         co = ((ua + ub) > 64'hFFFF_FFFF);
         sr = sa + sb;
      end
      ovf = (sr != longint'($signed(s)));
      return {co, ovf, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for o_done with a bounded cycle budget, counting busy cycles seen on the way
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (bus.o_done !== 1'b1 && lat < int'(4 * NIB + 8)) begin
         if (bus.o_busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
      chk("done_seen", 64'(bus.o_done), 64'(1'b1));
   endtask

   task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic sub,
                             input logic [31:0] es, input logic eco, input logic eovf);
      int lat;
      int bc;
      bus.i_a = a;
      bus.i_b = b;
      bus.i_sub = sub;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk("busy_after_accept", 64'(bus.o_busy), 64'(1'b1));
      chk("s_cleared", 64'(bus.o_s), 64'(0));
      wait_done(lat, bc);
      chk("s", 64'(bus.o_s), 64'(es));
      chk("co", 64'(bus.o_co), 64'(eco));
      chk("ovf", 64'(bus.o_ovf), 64'(eovf));
      chk("latency", 64'(lat), 64'(NIB));
      chk("busy_cycles", 64'(bc), 64'(NIB));
      chk("busy_in_done", 64'(bus.o_busy), 64'(1'b0));
      tick();
      chk("done_one_cycle", 64'(bus.o_done), 64'(1'b0));
      chk("s_held", 64'(bus.o_s), 64'(es));
   endtask

   task automatic pick(output logic [31:0] a, output logic [31:0] b, output logic sub);
      a   = $urandom;
      b   = $urandom;
      sub = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
         0: a = 32'h7FFF_FFFF;
         1: b = 32'h8000_0000;
         2: a = 32'hFFFF_FFFF;
         3: b = a;
         default: ;
      endcase
   endtask

   // i_start held high: each op accepted in the DONE cycle of the previous one
   task automatic run_stream(input int n);
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [33:0] m;
      int          lat;
      int          bc;
      pick(a, b, sub);
      bus.i_a = a;
      bus.i_b = b;
      bus.i_sub = sub;
      bus.i_start = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         m = model(a, b, sub);
         chk("stream_busy", 64'(bus.o_busy), 64'(1'b1));
         bus.i_a = $urandom;
         bus.i_b = $urandom;
         bus.i_sub = 1'($urandom_range(0, 1));
         wait_done(lat, bc);
         chk("stream_s", 64'(bus.o_s), 64'(m[31:0]));
         chk("stream_co", 64'(bus.o_co), 64'(m[33]));
         chk("stream_ovf", 64'(bus.o_ovf), 64'(m[32]));
         chk("stream_latency", 64'(lat), 64'(NIB));
         if (i < n - 1) begin
            pick(a, b, sub);
            bus.i_a = a;
            bus.i_b = b;
            bus.i_sub = sub;
         end else begin
            bus.i_start = 1'b0;
         end
      end
      tick();
      chk("stream_end_idle", 64'({bus.o_busy, bus.o_done}), 64'(0));
   endtask

   vec_t vecs[10];

   initial begin
      int lat;
      int bc;
      int nd;
      int nb;

      vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
      vecs[9] = '{32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

      reset_n = 1'b0;
      bus.i_start = 1'b0;
      bus.i_sub = 1'b0;
      bus.i_a = '0;
      bus.i_b = '0;
      repeat (3) tick();
      chk("rst_busy", 64'(bus.o_busy), 64'(0));
      chk("rst_done", 64'(bus.o_done), 64'(0));
      chk("rst_s", 64'(bus.o_s), 64'(0));
      chk("rst_co_ovf", 64'({bus.o_co, bus.o_ovf}), 64'(0));
      reset_n = 1'b1;
      repeat (2) tick();
      chk("idle_after_rst", 64'({bus.o_busy, bus.o_done}), 64'(0));

      for (int i = 0; i < 10; i++)
         run_single(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].co, vecs[i].ovf);

      // Start pulse with new operands during BUSY must be ignored and not queued
      bus.i_a = 32'h0000_1234;
      bus.i_b = 32'h0000_4321;
      bus.i_sub = 1'b0;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      tick();
      tick();
      bus.i_a = 32'hFFFF_FFFF;
      bus.i_b = 32'h0000_0001;
      bus.i_sub = 1'b1;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      wait_done(lat, bc);
      chk("ign_latency", 64'(lat + 3), 64'(NIB));
      chk("ign_s", 64'(bus.o_s), 64'(32'h0000_5555));
      chk("ign_co_ovf", 64'({bus.o_co, bus.o_ovf}), 64'(0));
      nd = 0;
      nb = 0;
      repeat (15) begin
         tick();
         if (bus.o_done === 1'b1) nd++;
         if (bus.o_busy === 1'b1) nb++;
      end
      chk("ign_no_second_done", 64'(nd), 64'(0));
      chk("ign_no_second_busy", 64'(nb), 64'(0));

      // Reset during the fourth BUSY cycle aborts at once
      bus.i_a = 32'h1111_1111;
      bus.i_b = 32'h2222_2222;
      bus.i_sub = 1'b0;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      repeat (3) tick();
      chk("partial_s", 64'(bus.o_s), 64'(32'h0000_0333));
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.o_busy), 64'(0));
      chk("abort_s", 64'(bus.o_s), 64'(0));
      chk("abort_done_co_ovf", 64'({bus.o_done, bus.o_co, bus.o_ovf}), 64'(0));
      repeat (2) tick();
      reset_n = 1'b1;
      nd = 0;
      nb = 0;
      repeat (12) begin
         tick();
         if (bus.o_done === 1'b1) nd++;
         if (bus.o_busy === 1'b1) nb++;
      end
      chk("abort_no_done", 64'(nd), 64'(0));
      chk("abort_no_busy", 64'(nb), 64'(0));
      run_single(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

      run_stream(3);
      tick();
      run_stream(1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
